// File: rtl/mcb_arb_pkg.sv
// Shared types and helpers for the MCB user-port arbiter: FSM states,
// fixed maximum requester count and the round-robin pick function.
package mcb_arb_pkg;

  localparam int MAX_REQ = 4;
  localparam int PTR_W   = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    XFER,
    DONE
  } arbState_e;

  // Walks offsets from the highest down so the lowest offset from ptr wins last.
  function automatic logic [MAX_REQ-1:0] rrPick(input logic [MAX_REQ-1:0] req,
                                                input logic [PTR_W-1:0]   ptr,
                                                input int                 numReq);
    logic [MAX_REQ-1:0] pick;
    int idx;
    pick = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < numReq) begin
        idx = (int'(ptr) + k) % numReq;
        if (req[idx]) begin
          pick      = '0;
          pick[idx] = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after the
// pointer (wrapping), returned one-hot together with a valid flag.
module rr_pick
  import mcb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               valid_o
);

  logic [MAX_REQ-1:0] reqPad;
  logic [MAX_REQ-1:0] pick;

  always_comb begin
    reqPad                = '0;
    reqPad[NUM_REQ-1:0]   = req_i;
  end

  assign pick    = rrPick(reqPad, ptr_i, NUM_REQ);
  assign gnt_o   = pick[NUM_REQ-1:0];
  assign valid_o = |pick;

endmodule

// File: rtl/mcb_port_arbiter.sv
// Round-robin sharing of the ddruser user port between NUM_REQ requesters,
// one grant per burst. Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module mcb_port_arbiter
  import mcb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 30,
  parameter int LEN_W   = 7,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      calib_done_i,
  input  logic [NUM_REQ-1:0]        m_req_i,
  input  logic [NUM_REQ-1:0]        m_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] m_addr_i,
  input  logic [NUM_REQ*LEN_W-1:0]  m_len_i,
  input  logic [NUM_REQ*DATA_W-1:0] m_wdata_i,
  input  logic [NUM_REQ-1:0]        m_wr_en_i,
  input  logic [NUM_REQ-1:0]        m_rd_en_i,
  output logic [NUM_REQ-1:0]        m_gnt_o,
  output logic [NUM_REQ-1:0]        m_wr_rdy_o,
  output logic [NUM_REQ-1:0]        m_rd_rdy_o,
  output logic [DATA_W-1:0]         m_rdata_o,
  output logic [NUM_REQ-1:0]        m_done_o,
  output logic                      u_wr_cmd_en_o,
  output logic [ADDR_W-1:0]         u_wr_addr_o,
  output logic [LEN_W-1:0]          u_wr_len_o,
  output logic                      u_wr_en_o,
  output logic [DATA_W-1:0]         u_wr_data_o,
  input  logic                      u_wr_rdy_i,
  input  logic                      u_wr_cmd_done_i,
  output logic                      u_rd_cmd_en_o,
  output logic [ADDR_W-1:0]         u_rd_addr_o,
  output logic [LEN_W-1:0]          u_rd_len_o,
  output logic                      u_rd_en_o,
  input  logic [DATA_W-1:0]         u_rd_data_i,
  input  logic                      u_rd_rdy_i,
  input  logic                      u_rd_cmd_done_i,
  output logic                      arb_err_o
);

  arbState_e            state_q, state_d;
  logic [NUM_REQ-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic                 cmdEn_q, cmdEn_d;

  logic [NUM_REQ-1:0]   pickGnt;
  logic                 pickValid;
  logic [ADDR_W-1:0]    pickAddr;
  logic [LEN_W-1:0]     pickLen;
  logic                 pickWe;
  logic [DATA_W-1:0]    ownerWdata;
  logic [PTR_W-1:0]     nextPtr;
  logic                 doneMatch;
  logic                 timeoutHit;
  logic                 inXfer;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) uPick (
    .req_i  (m_req_i),
    .ptr_i  (ptr_q),
    .gnt_o  (pickGnt),
    .valid_o(pickValid)
  );

  // One-hot selects avoid variable indexing into the packed requester buses.
  always_comb begin
    pickAddr   = '0;
    pickLen    = '0;
    pickWe     = 1'b0;
    ownerWdata = '0;
    nextPtr    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pickGnt[i]) begin
        pickAddr = m_addr_i[i*ADDR_W +: ADDR_W];
        pickLen  = m_len_i[i*LEN_W +: LEN_W];
        pickWe   = m_we_i[i];
      end
      if (owner_q[i]) begin
        ownerWdata = m_wdata_i[i*DATA_W +: DATA_W];
        nextPtr    = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  assign inXfer    = (state_q == XFER);
  assign doneMatch = we_q ? u_wr_cmd_done_i : u_rd_cmd_done_i;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    we_d    = we_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cmdEn_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (calib_done_i && pickValid) begin
          owner_d      = pickGnt;
          we_d         = pickWe;
          addr_d       = pickAddr;
          addr_d[1:0]  = 2'b00;
          len_d        = pickLen;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cmdEn_d = 1'b1;
        state_d = XFER;
      end
      XFER: begin
        if (doneMatch || timeoutHit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        ptr_d   = nextPtr;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      cmdEn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cmdEn_q <= cmdEn_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  logic [TMR_W-1:0] timer_q;
  logic             err_q;

  // Counts from ISSUE onward so the limit is measured from the command pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == ISSUE || state_q == XFER) begin
        timer_q <= timer_q + TMR_W'(1);
      end else begin
        timer_q <= '0;
      end
      if (timeoutHit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign timeoutHit = inXfer && !doneMatch && (timer_q >= TMR_W'(TIMEOUT));
  assign arb_err_o  = err_q;
`else
  assign timeoutHit = 1'b0;
  assign arb_err_o  = 1'b0;
`endif

  assign m_gnt_o    = (state_q == ISSUE || inXfer) ? owner_q : '0;
  assign m_wr_rdy_o = (inXfer && u_wr_rdy_i) ? owner_q : '0;
  assign m_rd_rdy_o = (inXfer && u_rd_rdy_i) ? owner_q : '0;
  assign m_done_o   = (state_q == DONE) ? owner_q : '0;
  assign m_rdata_o  = u_rd_data_i;

  assign u_wr_cmd_en_o = cmdEn_q & we_q;
  assign u_rd_cmd_en_o = cmdEn_q & ~we_q;
  assign u_wr_addr_o   = addr_q;
  assign u_rd_addr_o   = addr_q;
  assign u_wr_len_o    = len_q;
  assign u_rd_len_o    = len_q;
  assign u_wr_en_o     = inXfer & |(m_wr_en_i & owner_q);
  assign u_rd_en_o     = inXfer & |(m_rd_en_i & owner_q);
  assign u_wr_data_o   = inXfer ? ownerWdata : '0;

endmodule

// File: tb/tb_mcb_port_arbiter.sv
// Randomised and directed bench for mcb_port_arbiter against a simple
// round-robin model; the watchdog scenario runs when ARB_TIMEOUT_EN is defined.
module tb_mcb_port_arbiter;

  localparam int NUM = 2;
  localparam int AW  = 30;
  localparam int LW  = 7;
  localparam int DW  = 32;
  localparam int TMO = 64;
  localparam int AWS = NUM * AW;
  localparam int LWS = NUM * LW;
  localparam int DWS = NUM * DW;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           calib;
  logic [NUM-1:0] mReq, mWe, mWrEn, mRdEn;
  logic [AWS-1:0] mAddr;
  logic [LWS-1:0] mLen;
  logic [DWS-1:0] mWdata;
  logic [NUM-1:0] mGnt, mWrRdy, mRdRdy, mDone;
  logic [DW-1:0]  mRdata;
  logic           uWrCmdEn, uWrEn, uWrRdy, uWrCmdDone;
  logic [AW-1:0]  uWrAddr, uRdAddr;
  logic [LW-1:0]  uWrLen, uRdLen;
  logic [DW-1:0]  uWrData, uRdData;
  logic           uRdCmdEn, uRdEn, uRdRdy, uRdCmdDone;
  logic           arbErr;

  int checkCount = 0;
  int errorCount = 0;
  int ptrModel   = 0;

  always #5 clk = ~clk;

  mcb_port_arbiter #(
    .NUM_REQ(NUM), .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW), .TIMEOUT(TMO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .calib_done_i   (calib),
    .m_req_i        (mReq),
    .m_we_i         (mWe),
    .m_addr_i       (mAddr),
    .m_len_i        (mLen),
    .m_wdata_i      (mWdata),
    .m_wr_en_i      (mWrEn),
    .m_rd_en_i      (mRdEn),
    .m_gnt_o        (mGnt),
    .m_wr_rdy_o     (mWrRdy),
    .m_rd_rdy_o     (mRdRdy),
    .m_rdata_o      (mRdata),
    .m_done_o       (mDone),
    .u_wr_cmd_en_o  (uWrCmdEn),
    .u_wr_addr_o    (uWrAddr),
    .u_wr_len_o     (uWrLen),
    .u_wr_en_o      (uWrEn),
    .u_wr_data_o    (uWrData),
    .u_wr_rdy_i     (uWrRdy),
    .u_wr_cmd_done_i(uWrCmdDone),
    .u_rd_cmd_en_o  (uRdCmdEn),
    .u_rd_addr_o    (uRdAddr),
    .u_rd_len_o     (uRdLen),
    .u_rd_en_o      (uRdEn),
    .u_rd_data_i    (uRdData),
    .u_rd_rdy_i     (uRdRdy),
    .u_rd_cmd_done_i(uRdCmdDone),
    .arb_err_o      (arbErr)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference arbitration: first requesting index at or after the pointer.
  function automatic int modelPick(input logic [NUM-1:0] req);
    int idx;
    for (int k = 0; k < NUM; k++) begin
      idx = (ptrModel + k) % NUM;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  // One full burst: starts from an idle arbiter, ends in the DONE cycle.
  task automatic applyStimulus(input logic [NUM-1:0] reqPat, input logic [NUM-1:0] wePat,
                               input logic [AWS-1:0] addrs, input logic [LWS-1:0] lens,
                               input int xferCycles, input bit directed);
    int             e;
    int             wrCount;
    bit             last;
    logic [NUM-1:0] eOh;
    logic           expWe;
    logic [AW-1:0]  expAddr;
    logic [LW-1:0]  expLen;
    @(negedge clk);
    calib = 1'b1; mReq = reqPat; mWe = wePat; mAddr = addrs; mLen = lens;
    mWrEn = '0; mRdEn = '0; uWrCmdDone = 1'b0; uRdCmdDone = 1'b0;
    #1;
    checkOutput("gntIdle", mGnt, 0);
    checkOutput("doneIdle", mDone, 0);
    e = modelPick(reqPat);
    eOh = '0;
    eOh[e] = 1'b1;
    expWe = wePat[e];
    expAddr = addrs[e*AW +: AW];
    expAddr[1:0] = 2'b00;
    expLen = lens[e*LW +: LW];
    @(negedge clk); #1;
    checkOutput("gntIssue", mGnt, eOh);
    checkOutput("cmdEnIssue", {uWrCmdEn, uRdCmdEn}, 0);
    wrCount = 0;
    for (int c = 0; c < xferCycles; c++) begin
      @(negedge clk);
      if (directed) begin
        mWrEn = '1; mRdEn = '0; uWrRdy = 1'b1; uRdRdy = 1'b0;
      end else begin
        mWrEn = NUM'($urandom); mRdEn = NUM'($urandom);
        uWrRdy = 1'($urandom); uRdRdy = 1'($urandom);
        mReq = NUM'($urandom); calib = 1'($urandom);
      end
      mWdata = {$urandom, $urandom};
      uRdData = $urandom;
      last = (c == xferCycles - 1);
      uWrCmdDone = last ? expWe  : (!expWe && !directed && $urandom_range(0, 1) == 1);
      uRdCmdDone = last ? !expWe : (expWe && !directed && $urandom_range(0, 1) == 1);
      #1;
      if (c == 0) begin
        checkOutput("wrCmdEn", uWrCmdEn, expWe);
        checkOutput("rdCmdEn", uRdCmdEn, !expWe);
        checkOutput("wrAddr", uWrAddr, expAddr);
        checkOutput("rdAddr", uRdAddr, expAddr);
        checkOutput("wrLen", uWrLen, expLen);
        checkOutput("rdLen", uRdLen, expLen);
      end else begin
        checkOutput("cmdEnXfer", {uWrCmdEn, uRdCmdEn}, 0);
      end
      checkOutput("gntXfer", mGnt, eOh);
      checkOutput("wrEn", uWrEn, mWrEn[e]);
      checkOutput("wrData", uWrData, mWdata[e*DW +: DW]);
      checkOutput("rdEn", uRdEn, mRdEn[e]);
      checkOutput("wrRdy", mWrRdy, uWrRdy ? eOh : '0);
      checkOutput("rdRdy", mRdRdy, uRdRdy ? eOh : '0);
      checkOutput("rdata", mRdata, uRdData);
      wrCount += int'(uWrEn);
    end
    @(negedge clk);
    uWrCmdDone = 1'b0; uRdCmdDone = 1'b0; mWrEn = '0; mRdEn = '0;
    mReq = reqPat; calib = 1'b1;
    #1;
    checkOutput("done", mDone, eOh);
    checkOutput("gntDone", mGnt, 0);
    if (directed) checkOutput("wrCount", wrCount, xferCycles);
    ptrModel = (e + 1) % NUM;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    logic [AWS-1:0] a;
    logic [LWS-1:0] l;
    rst_n = 1'b0; calib = 1'b0; mReq = '0; mWe = '0; mWrEn = '0; mRdEn = '0;
    mAddr = '0; mLen = '0; mWdata = '0; uWrRdy = 1'b0; uWrCmdDone = 1'b0;
    uRdData = '0; uRdRdy = 1'b0; uRdCmdDone = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rstGnt", mGnt, 0);
    checkOutput("rstDone", mDone, 0);
    checkOutput("rstCmdEn", {uWrCmdEn, uRdCmdEn}, 0);
    checkOutput("rstEn", {uWrEn, uRdEn}, 0);
    checkOutput("rstAddr", uWrAddr, 0);
    checkOutput("rstLen", uWrLen, 0);
    checkOutput("rstRdy", {mWrRdy, mRdRdy}, 0);
    checkOutput("rstErr", arbErr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single write: requester 0, unaligned address, len 7, eight strobes.
    a = AWS'($urandom);
    a[AW-1:0] = AW'(32'h0000_0103);
    l = LWS'($urandom);
    l[LW-1:0] = LW'(7);
    applyStimulus(2'b01, 2'b01, a, l, 8, 1'b1);

    // Read isolation: requester 1 reads len 3 while requester 0 strobes.
    a = AWS'({$urandom, $urandom});
    l = LWS'($urandom);
    l[2*LW-1:LW] = LW'(3);
    applyStimulus(2'b10, 2'b00, a, l, 4, 1'b0);

    // Calibration gate.
    @(negedge clk);
    calib = 1'b0; mReq = 2'b01;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      checkOutput("calibGate", mGnt, 0);
    end
    applyStimulus(2'b01, NUM'($urandom), AWS'({$urandom, $urandom}), LWS'($urandom), 3, 1'b0);

    // Leave the pointer at 1, then reset in the middle of a burst.
    applyStimulus(2'b01, 2'b01, AWS'({$urandom, $urandom}), LWS'($urandom), 2, 1'b0);
    @(negedge clk);
    calib = 1'b1; mReq = 2'b01; mWe = 2'b01;
    @(negedge clk);
    @(negedge clk);
    mWrEn = '1; uWrRdy = 1'b1; uRdRdy = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstGnt", mGnt, 0);
    checkOutput("midRstWrEn", uWrEn, 0);
    checkOutput("midRstRdy", {mWrRdy, mRdRdy}, 0);
    checkOutput("midRstCmd", {uWrCmdEn, uRdCmdEn}, 0);
    checkOutput("midRstDone", mDone, 0);
    @(negedge clk);
    rst_n = 1'b1; mReq = '0; mWrEn = '0;
    ptrModel = 0;
    applyStimulus(2'b11, NUM'($urandom), AWS'({$urandom, $urandom}), LWS'($urandom), 2, 1'b0);
    applyStimulus(2'b10, NUM'($urandom), AWS'({$urandom, $urandom}), LWS'($urandom), 2, 1'b0);

    // Contention: both requesting for four bursts.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b11, NUM'($urandom), AWS'({$urandom, $urandom}), LWS'($urandom),
                    int'($urandom_range(1, 4)), 1'b0);
    end

    for (int i = 0; i < 40; i++) begin
      applyStimulus(NUM'($urandom_range(1, 3)), NUM'($urandom), AWS'({$urandom, $urandom}),
                    LWS'($urandom), int'($urandom_range(1, 5)), 1'b0);
    end

`ifdef ARB_TIMEOUT_EN
    begin : timeoutCase
      int             k;
      int             e;
      logic [NUM-1:0] eOh;
      @(negedge clk);
      calib = 1'b1; mReq = 2'b01; mWe = 2'b01; uWrCmdDone = 1'b0; uRdCmdDone = 1'b0;
      e = modelPick(2'b01);
      eOh = '0;
      eOh[e] = 1'b1;
      @(negedge clk);
      @(negedge clk); #1;
      checkOutput("toCmdEn", uWrCmdEn, 1);
      k = 0;
      while (mDone == '0 && k < 200) begin
        @(negedge clk); #1;
        k++;
      end
      checkOutput("toLatency", k, TMO);
      checkOutput("toDone", mDone, eOh);
      checkOutput("toErr", arbErr, 1);
      ptrModel = (e + 1) % NUM;
    end
    applyStimulus(2'b11, NUM'($urandom), AWS'({$urandom, $urandom}), LWS'($urandom), 3, 1'b0);
    checkOutput("errSticky", arbErr, 1);
`else
    checkOutput("errTied", arbErr, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
